// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file with scoreboard.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write->read bypass).
package regfile_pkg;

  localparam int XLEN_DEF   = 64;
  localparam int NREGS_DEF  = 32;
  localparam int AW_DEF     = $clog2(NREGS_DEF);
  // Upper bound on write ports handled by wr_winner().
  localparam int MAX_WPORTS = 32;

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xdata_t;

  // Highest-indexed set bit of a per-write-port match vector, -1 when none.
  // Highest port wins on same-address collisions.
  function automatic int wr_winner(input logic [MAX_WPORTS-1:0] hit);
    int w;
    w = -1;
    for (int j = 0; j < MAX_WPORTS; j++) begin
      if (hit[j]) w = j;
    end
    return w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register, set by
// reservations from decode and cleared by writeback. Register 0 is never busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int NWRITE = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NWRITE-1:0]    wr_en,
  input  logic [NWRITE*AW-1:0] wr_addr,
  input  logic [NWRITE-1:0]    wr_clr,
  input  logic                 rsv_en,
  input  logic [AW-1:0]        rsv_addr,
  output logic [NREGS-1:0]     busy_vec,
  output logic                 any_busy
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [NREGS-1:0] clr_hit;

  // Next busy state: colliding writes resolve to the highest port's wr_clr;
  // a same-cycle reservation beats a clear since it belongs to a newer producer.
  always_comb begin
    clr_hit = '0;
    busy_d  = busy_q;
    for (int r = 1; r < NREGS; r++) begin
      for (int j = 0; j < NWRITE; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] == AW'(r)) clr_hit[r] = wr_clr[j];
      end
      if (rsv_en && rsv_addr == AW'(r)) busy_d[r] = 1'b1;
      else if (clr_hit[r])              busy_d[r] = 1'b0;
    end
    busy_d[0] = 1'b0;
    if (reset) busy_d = '0;
  end

  // Busy bit storage.
  always_ff @(posedge clk) begin
    busy_q <= busy_d;
  end

  assign busy_vec = busy_q;
  assign any_busy = |busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with integrated busy-bit scoreboard.
// Reads are combinational; writes commit at posedge. x0 reads 0, never busy.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data (and the
// busy clear) to matching read ports; busy_vec stays registered either way.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NREAD  = 2,
  parameter int NWRITE = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*XLEN-1:0]  rd_data,
  output logic [NREAD-1:0]       rd_busy,
  input  logic [NWRITE-1:0]      wr_en,
  input  logic [NWRITE*AW-1:0]   wr_addr,
  input  logic [NWRITE*XLEN-1:0] wr_data,
  input  logic [NWRITE-1:0]      wr_clr,
  input  logic                   rsv_en,
  input  logic [AW-1:0]          rsv_addr,
  output logic [NREGS-1:0]       busy_vec,
  output logic                   any_busy
);

  logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;

  // Next register contents: ports applied in ascending order so the highest
  // port wins a collision; x0 is pinned to zero; reset clears everything.
  always_comb begin
    regs_d = regs_q;
    for (int j = 0; j < NWRITE; j++) begin
      if (wr_en[j] && wr_addr[j*AW +: AW] != '0)
        regs_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
    end
    regs_d[0] = '0;
    if (reset) regs_d = '0;
  end

  // Register storage.
  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .NWRITE (NWRITE)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_clr   (wr_clr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy_vec (busy_vec),
    .any_busy (any_busy)
  );

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rf_data;
    logic            rf_busy;

    assign ra      = rd_addr[i*AW +: AW];
    assign rf_data = (ra == '0) ? '0 : regs_q[ra];
    assign rf_busy = busy_vec[ra];

`ifdef REGFILE_BYPASS_EN
    logic [MAX_WPORTS-1:0] hit;
    logic [XLEN-1:0]       byp_data;
    logic                  byp_busy;
    int                    w;

    // Which write ports target this read address this cycle (x0 excluded).
    always_comb begin
      hit = '0;
      for (int j = 0; j < NWRITE; j++) begin
        hit[j] = wr_en[j] && (wr_addr[j*AW +: AW] == ra) && (ra != '0);
      end
    end

    // Forward the winning write; its clear hides busy unless re-reserved now.
    always_comb begin
      w        = wr_winner(hit);
      byp_data = rf_data;
      byp_busy = rf_busy;
      for (int j = 0; j < NWRITE; j++) begin
        if (j == w) begin
          byp_data = wr_data[j*XLEN +: XLEN];
          if (wr_clr[j] && !(rsv_en && rsv_addr == ra)) byp_busy = 1'b0;
        end
      end
    end

    assign rd_data[i*XLEN +: XLEN] = byp_data;
    assign rd_busy[i]              = byp_busy;
`else
    assign rd_data[i*XLEN +: XLEN] = rf_data;
    assign rd_busy[i]              = rf_busy;
`endif
  end

endmodule
